// File: rtl/btb_update_queue.sv
// ---------------------------------------------------------------------------
// btb_update_queue
//
// Decoupling buffer between backend branch resolution and the frontend BTB
// update port. Resolved-mispredict updates (pc, target) are queued in a small
// circular buffer and drained one per cycle whenever the BTB side accepts.
// A new update whose pc already sits in the queue overwrites that entry's
// target in place, so a stale target can never be written after a fresh one.
// Updates are ignored in debug mode; updates lost to overflow are counted.
//
// Ports:
//   clk_i          clock, rising edge
//   rst_ni         synchronous active-low reset
//   flush_i        discard all queued updates (drop counter is kept)
//   debug_mode_i   core in debug mode; incoming updates are ignored
//   upd_valid_i    resolved mispredict update present (no backpressure)
//   upd_pc_i       pc of the resolved control-flow instruction
//   upd_target_i   resolved target address
//   btb_ready_i    BTB side accepts the head entry this cycle
//   btb_valid_o    head entry valid
//   btb_pc_o       head entry pc
//   btb_target_o   head entry target
//   occupancy_o    number of valid entries (0..DEPTH)
//   drop_cnt_o     saturating count of updates lost to overflow
// ---------------------------------------------------------------------------
module btb_update_queue #(
    parameter int unsigned VLEN  = 64,
    parameter int unsigned DEPTH = 4,
    parameter int unsigned CNT_W = 16
) (
    input  logic                     clk_i,
    input  logic                     rst_ni,
    input  logic                     flush_i,
    input  logic                     debug_mode_i,
    input  logic                     upd_valid_i,
    input  logic [VLEN-1:0]          upd_pc_i,
    input  logic [VLEN-1:0]          upd_target_i,
    input  logic                     btb_ready_i,
    output logic                     btb_valid_o,
    output logic [VLEN-1:0]          btb_pc_o,
    output logic [VLEN-1:0]          btb_target_o,
    output logic [$clog2(DEPTH):0]   occupancy_o,
    output logic [CNT_W-1:0]         drop_cnt_o
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned OCC_W = PTR_W + 1;

    // Storage and bookkeeping
    logic [VLEN-1:0]  pc_q    [DEPTH];
    logic [VLEN-1:0]  tgt_q   [DEPTH];
    logic [DEPTH-1:0] valid_q;
    logic [PTR_W-1:0] head_q;
    logic [PTR_W-1:0] tail_q;
    logic [OCC_W-1:0] count_q;
    logic [CNT_W-1:0] drop_q;

    // Per-cycle control
    logic             pop;
    logic             accept;
    logic             full;
    logic [DEPTH-1:0] match;
    logic             coalesce;
    logic             push;
    logic             drop;

    assign btb_valid_o  = (count_q != '0);
    assign btb_pc_o     = pc_q[head_q];
    assign btb_target_o = tgt_q[head_q];
    assign occupancy_o  = count_q;
    assign drop_cnt_o   = drop_q;

    assign pop    = btb_valid_o && btb_ready_i;
    assign accept = upd_valid_i && !debug_mode_i && !flush_i;
    assign full   = (count_q == OCC_W'(DEPTH));

    // Full-width pc compare against every valid entry. The head entry is
    // excluded while it is being popped: its old target is leaving the queue
    // this cycle, so the update must be re-queued instead of being lost.
    // NOTE: match gets a default before the loop so no path leaves it
    // unassigned, which would otherwise infer a latch.
    always_comb begin
        match = '0;
        for (int i = 0; i < DEPTH; i++) begin
            match[i] = valid_q[i] && (pc_q[i] == upd_pc_i)
                       && !(pop && (PTR_W'(i) == head_q));
        end
    end

    assign coalesce = accept && (match != '0);
    assign push     = accept && !coalesce && (!full || pop);
    assign drop     = accept && !coalesce && full && !pop;

    // NOTE: all state below uses non-blocking assignments so every register
    // sees pre-edge values; later assignments to the same valid bit win,
    // which lets a push into the slot being popped (full + pop) keep it valid.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            // NOTE: storage contents are reset too, because the head entry is
            // visible on btb_pc_o/btb_target_o and must read 0 out of reset.
            for (int i = 0; i < DEPTH; i++) begin
                pc_q[i]  <= '0;
                tgt_q[i] <= '0;
            end
            valid_q <= '0;
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
            drop_q  <= '0;
        end else if (flush_i) begin
            // Flush discards traffic but keeps the drop statistic.
            valid_q <= '0;
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            if (drop && (drop_q != '1)) begin
                drop_q <= drop_q + CNT_W'(1);
            end

            if (pop) begin
                valid_q[head_q] <= 1'b0;
                head_q          <= head_q + PTR_W'(1);
            end

            if (coalesce) begin
                for (int i = 0; i < DEPTH; i++) begin
                    if (match[i]) begin
                        tgt_q[i] <= upd_target_i;
                    end
                end
            end

            if (push) begin
                pc_q[tail_q]    <= upd_pc_i;
                tgt_q[tail_q]   <= upd_target_i;
                valid_q[tail_q] <= 1'b1;
                tail_q          <= tail_q + PTR_W'(1);
            end

            count_q <= count_q + OCC_W'(push) - OCC_W'(pop);
        end
    end

endmodule

// File: doc/btb_update_queue.md
Name: btb_update_queue

Overview:
- Decoupling buffer between branch resolution in the backend and the frontend BTB update port.
- Captures resolved-mispredict updates (pc, target) and drains them one per cycle when the BTB side accepts.
- Coalesces repeated updates to the same pc so stale targets are never written after fresh ones.
- Drops updates in debug mode and counts overflow drops for performance analysis.

Parameters:
- VLEN, 64, virtual address width (matches riscv::VLEN).
- DEPTH, 4, number of queue entries; power of two, >= 2.
- CNT_W, 16, width of the saturating drop counter.

Ports:
- clk_i  input  1  clock, rising edge
- rst_ni  input  1  reset, synchronous, active-low
- flush_i  input  1  discard all queued updates
- debug_mode_i  input  1  core in debug mode; incoming updates ignored
- upd_valid_i  input  1  resolved mispredict update present this cycle (no backpressure)
- upd_pc_i  input  VLEN  pc of the resolved control-flow instruction
- upd_target_i  input  VLEN  resolved target address
- btb_ready_i  input  1  BTB side accepts the head entry this cycle
- btb_valid_o  output  1  head entry valid
- btb_pc_o  output  VLEN  head entry pc
- btb_target_o  output  VLEN  head entry target
- occupancy_o  output  $clog2(DEPTH)+1  number of valid entries
- drop_cnt_o  output  CNT_W  saturating count of updates lost to overflow

Behaviour:
- Clock and reset: single clock clk_i. Reset is synchronous, active-low on rst_ni.
- Reset state:
  - all entries invalid; storage pc/target cleared to 0; head and tail pointers 0.
  - btb_valid_o=0, btb_pc_o=0, btb_target_o=0, occupancy_o=0, drop_cnt_o=0.
- Storage and pointers:
  - circular buffer, head/tail pointers wrap modulo DEPTH.
  - full/empty are tracked by a count register, not pointer equality.
- Output timing:
  - btb_valid_o = (count != 0); btb_pc_o/btb_target_o come straight from the head entry.
  - pop occurs when btb_valid_o && btb_ready_i; the head advances at the next edge.
- Accept condition: an incoming update is considered only when upd_valid_i && !debug_mode_i && !flush_i.
- Accept rules, evaluated in priority order each cycle:
  1. Coalesce: if upd_pc_i equals the pc of a valid entry (full VLEN compare), that entry's target is overwritten in place; no push; count unchanged by the update. Exception: a match on the head entry while the head is popped this cycle does not coalesce; the update is handled by rule 2 or 3.
  2. Push: if not full, or full with a pop this cycle, write the update at tail; tail+1. Count = count + push - pop.
  3. Drop: full with no pop. The update is discarded; drop_cnt_o increments, saturating at 2^CNT_W-1.
- Invariant: at most one valid entry per pc; multiple matches cannot occur.
- Latency: an update accepted at cycle N is visible on btb_* at cycle N+1 at the earliest. A coalesced update changes btb_target_o at N+1 if it hit the head.
- Ordering: drain order is FIFO by first-insertion; coalescing keeps the original slot.
- debug_mode_i:
  - only gates input; queued entries continue to drain.
  - ignored updates are not counted as drops.
- flush_i:
  - at the next edge, count=0, pointers=0, all entries invalid.
  - a same-cycle pop or update is discarded; btb_valid_o is 0 in the following cycle.
  - drop_cnt_o is retained.
- Reset mid-operation (rst_ni low at an edge) overrides flush and all traffic; the reset state above applies.
- occupancy_o equals the registered count; it never exceeds DEPTH.

Test Plan:
1. After reset, push pc=0x1000/tgt=0x2000 with btb_ready_i=0 -> next cycle btb_valid_o=1, pc=0x1000, target=0x2000, occupancy=1. Raise ready -> pops; following cycle btb_valid_o=0.
2. Coalesce: queue pc 0x1000/tgt 0x2000 and pc 0x1004/tgt 0x3000, ready=0. Send pc 0x1000/tgt 0x4000 -> occupancy stays 2; drain order is (0x1000,0x4000) then (0x1004,0x3000).
3. Overflow: DEPTH=4, ready=0, send 6 distinct pcs -> occupancy=4, drop_cnt_o=2. Sixth update sent with ready=1 on a full queue -> accepted, drop_cnt unchanged.
4. Head-pop race: single entry pc 0x1000, ready=1, same cycle update pc 0x1000/tgt 0x5000 -> old entry drains, new entry pushed; next cycle btb_target_o=0x5000, occupancy=1.
5. debug_mode_i=1 with 3 updates -> occupancy unchanged, drop_cnt unchanged. Pre-existing entries still drain.
6. Flush with 3 entries queued and an update present -> next cycle occupancy=0, btb_valid_o=0, drop_cnt retained. Wrap check: after 2*DEPTH push/pop cycles, FIFO order is preserved.
